uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 118 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ byte producers share one UART TX FIFO.
// Each grant lasts one packet, MAX_BURST bytes, or until the owner stalls for TIMEOUT cycles.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     last,
    input  logic [8*NUM_REQ-1:0]   data,
    output logic [NUM_REQ-1:0]     ack,
    input  logic                   tx_full,
    output logic                   wr_uart,
    output logic [7:0]             w_data,
    output logic [2:0]             owner,
    output logic                   busy,
    output logic                   drop
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [2:0] LAST_IDX  = 3'(NUM_REQ - 1);
    localparam logic [7:0] BURST_END = 8'(MAX_BURST - 1);
    localparam logic [9:0] STALL_MAX = 10'(TIMEOUT);

    state_t     state, state_nx;
    logic [2:0] rr_ptr;
    logic [2:0] pick;
    logic [7:0] byte_cnt;
    logic [9:0] stall_cnt;
    logic       sel_req, sel_last;
    logic [7:0] sel_data;
    logic       burst_end, timeout, release_grant;

    // Owner's request lines, muxed by the registered owner index.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default first, so no latch is inferred.
        sel_req  = 1'b0;
        sel_last = 1'b0;
        sel_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == 3'(i)) begin
                sel_req  = req[i];
                sel_last = last[i];
                sel_data = data[8*i +: 8];
            end
        end
    end

    // Search upward from rr_ptr+1; the outer loop runs backwards so the nearest set bit wins.
    always_comb begin
        pick = 3'd0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (rr_ptr == 3'(j) && req[(j + i) % NUM_REQ])
                    pick = 3'((j + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        busy          = (state == BUSY);
        wr_uart       = busy & sel_req & ~tx_full;
        w_data        = busy ? sel_data : 8'h00;
        burst_end     = wr_uart & (sel_last | (byte_cnt == BURST_END));
        // A returning request in the cycle the counter hits the limit wins over the timeout.
        timeout       = busy & ~sel_req & (stall_cnt == STALL_MAX);
        drop          = timeout;
        release_grant = burst_end | timeout;
        ack           = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == 3'(i))
                ack[i] = wr_uart;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|req) state_nx = BUSY;
            BUSY:    if (release_grant) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner     <= 3'd0;
            rr_ptr    <= LAST_IDX;
            byte_cnt  <= 8'd0;
            stall_cnt <= 10'd0;
        end else if (state == IDLE) begin
            if (|req) begin
                owner     <= pick;
                byte_cnt  <= 8'd0;
                stall_cnt <= 10'd0;
            end
        end else begin
            if (wr_uart)
                byte_cnt <= byte_cnt + 8'd1;
            // Only a missing request is a stall; a full FIFO is back-pressure, not a stall.
            stall_cnt <= sel_req ? 10'd0 : stall_cnt + 10'd1;
            if (release_grant)
                rr_ptr <= owner;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: behavioural requesters feed byte queues, a monitor
// logs writes and grants, and each scenario compares the logs with hand-computed values.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset = 1'b1;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] data;
    logic [3:0]  ack;
    logic        tx_full;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic [2:0]  owner;
    logic        busy;
    logic        drop;

    uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(16), .TIMEOUT(64)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .last    (last),
        .data    (data),
        .ack     (ack),
        .tx_full (tx_full),
        .wr_uart (wr_uart),
        .w_data  (w_data),
        .owner   (owner),
        .busy    (busy),
        .drop    (drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Requester model: per-requester byte queue, {last, byte} per entry.
    logic [8:0] mem [4][32];
    int         head [4];
    int         tail [4];
    logic [3:0] en;

    // Monitor state and logs.
    int   wr_owner [$];
    int   wr_byte  [$];
    int   gr_owner [$];
    int   gr_gap   [$];
    int   drop_cnt;
    int   idle_run;
    logic prev_busy;
    logic o_busy, o_wr, o_drop;
    logic [3:0] o_ack;
    logic [2:0] o_owner;
    logic [7:0] o_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_inputs();
        for (int i = 0; i < 4; i++) begin
            if (en[i] && head[i] < tail[i]) begin
                req[i]         = 1'b1;
                data[8*i +: 8] = mem[i][head[i]][7:0];
                last[i]        = mem[i][head[i]][8];
            end else begin
                req[i]         = 1'b0;
                data[8*i +: 8] = 8'h00;
                last[i]        = 1'b0;
            end
        end
    endtask

    task automatic load(input int r, input logic [7:0] b, input logic l);
        mem[r][tail[r]] = {l, b};
        tail[r]++;
    endtask

    // One clock: observe at the falling edge, advance the requester queues after the rising edge.
    task automatic cycle();
        @(negedge clk);
        o_busy  = busy;
        o_wr    = wr_uart;
        o_ack   = ack;
        o_owner = owner;
        o_data  = w_data;
        o_drop  = drop;
        if (!o_busy) begin
            check("idle_quiet", {19'd0, o_wr, o_ack, o_data}, 32'd0);
        end else if (o_wr) begin
            check("ack_onehot", {28'd0, o_ack}, 32'd1 << o_owner);
            check("w_data", {24'd0, o_data}, {24'd0, mem[o_owner][head[o_owner]][7:0]});
            wr_owner.push_back(int'(o_owner));
            wr_byte.push_back(int'(o_data));
        end else begin
            check("ack_idle_write", {28'd0, o_ack}, 32'd0);
        end
        if (o_busy && !prev_busy) begin
            gr_owner.push_back(int'(o_owner));
            gr_gap.push_back(idle_run);
            idle_run = 0;
        end
        if (!o_busy) idle_run++;
        if (o_drop) drop_cnt++;
        prev_busy = o_busy;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (o_ack[i]) head[i]++;
        set_inputs();
    endtask

    task automatic run_until_writes(input string tag, input int n, input int budget);
        int k = 0;
        while (wr_owner.size() < n && k < budget) begin
            cycle();
            k++;
        end
        check(tag, wr_owner.size(), n);
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            cycle();
            k++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        tx_full = 1'b0;
        en      = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        set_inputs();
        wr_owner.delete();
        wr_byte.delete();
        gr_owner.delete();
        gr_gap.delete();
        drop_cnt  = 0;
        idle_run  = 0;
        prev_busy = 1'b0;
        #1;
        check("rst_outputs", {18'd0, busy, wr_uart, drop, ack, w_data}, 32'd0);
        check("rst_owner", {29'd0, owner}, 32'd0);
        repeat (2) cycle();
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_b;
        int exp_o;
        #2;
        do_reset();

        // Single requester 2, three-byte packet.
        load(2, 8'h11, 1'b0);
        load(2, 8'h22, 1'b0);
        load(2, 8'h33, 1'b1);
        en = 4'b1111;
        set_inputs();
        run_until_writes("s1_writes", 3, 20);
        check("s1_grant_owner", gr_owner[0], 2);
        check("s1_byte0", wr_byte[0], 32'h11);
        check("s1_byte1", wr_byte[1], 32'h22);
        check("s1_byte2", wr_byte[2], 32'h33);
        check("s1_owner2", wr_owner[2], 2);
        check("s1_idle_after", {31'd0, busy}, 32'd0);
        check("s1_grants", gr_owner.size(), 1);

        // All four requesting, one-byte packets: round-robin 0,1,2,3,0.
        do_reset();
        load(0, 8'h01, 1'b1);
        load(1, 8'h02, 1'b1);
        load(2, 8'h03, 1'b1);
        load(3, 8'h04, 1'b1);
        load(0, 8'h05, 1'b1);
        en = 4'b1111;
        set_inputs();
        run_until_writes("s2_writes", 5, 30);
        check("s2_ngrants", gr_owner.size(), 5);
        for (int k = 0; k < 5; k++) begin
            exp_o = (k == 4) ? 0 : k;
            check("s2_grant", gr_owner[k], exp_o);
            check("s2_byte", wr_byte[k], k + 1);
            if (k > 0) check("s2_gap", gr_gap[k], 1);
        end

        // Requester 1 streams 20 bytes without last; burst limit hands over to requester 0.
        do_reset();
        for (int k = 0; k < 20; k++) load(1, 8'(8'hA0 + k), 1'b0);
        load(0, 8'h5A, 1'b1);
        en = 4'b0010;
        set_inputs();
        cycle();
        en = 4'b0011;
        set_inputs();
        run_until_writes("s3_writes", 21, 80);
        for (int k = 0; k < 21; k++) begin
            exp_o = (k == 16) ? 0 : 1;
            exp_b = (k == 16) ? 32'h5A : ((k < 16) ? 32'hA0 + k : 32'hA0 + k - 1);
            check("s3_owner", wr_owner[k], exp_o);
            check("s3_byte", wr_byte[k], exp_b);
        end
        check("s3_ngrants", gr_owner.size(), 3);
        check("s3_grant0", gr_owner[0], 1);
        check("s3_grant1", gr_owner[1], 0);
        check("s3_grant2", gr_owner[2], 1);
        run_until_idle("s3_timeout_idle", 100);
        check("s3_drop", drop_cnt, 1);

        // FIFO full for 100 cycles mid-packet: no write, no timeout, resume when it clears.
        do_reset();
        load(3, 8'hC0, 1'b0);
        load(3, 8'hC1, 1'b0);
        load(3, 8'hC2, 1'b0);
        load(3, 8'hC3, 1'b1);
        en = 4'b1111;
        set_inputs();
        run_until_writes("s4_first2", 2, 10);
        tx_full = 1'b1;
        repeat (100) cycle();
        check("s4_nowrite", wr_owner.size(), 2);
        check("s4_nodrop", drop_cnt, 0);
        check("s4_busy_held", {31'd0, busy}, 32'd1);
        tx_full = 1'b0;
        cycle();
        check("s4_resume", wr_owner.size(), 3);
        run_until_writes("s4_all", 4, 10);
        check("s4_byte3", wr_byte[3], 32'hC3);
        check("s4_idle", {31'd0, busy}, 32'd0);

        // Owner stalls: 63 and 64 quiet cycles are forgiven, 65 triggers the drop.
        do_reset();
        load(1, 8'hD0, 1'b0);
        load(1, 8'hD1, 1'b0);
        load(1, 8'hD2, 1'b0);
        load(1, 8'hD3, 1'b1);
        en = 4'b0010;
        set_inputs();
        run_until_writes("s5_first", 1, 10);
        en = 4'b0000;
        set_inputs();
        repeat (63) cycle();
        check("s5_63_nodrop", drop_cnt, 0);
        en = 4'b0010;
        set_inputs();
        cycle();
        check("s5_63_write", wr_owner.size(), 2);
        en = 4'b0000;
        set_inputs();
        repeat (64) cycle();
        check("s5_64_nodrop", drop_cnt, 0);
        check("s5_64_busy", {31'd0, busy}, 32'd1);
        en = 4'b0010;
        set_inputs();
        cycle();
        check("s5_64_write", wr_owner.size(), 3);
        check("s5_64_byte", wr_byte[2], 32'hD2);
        check("s5_64_still_nodrop", drop_cnt, 0);
        en = 4'b0000;
        set_inputs();
        repeat (64) cycle();
        check("s5_pre_drop", drop_cnt, 0);
        cycle();
        check("s5_drop_pulse", {30'd0, o_drop, o_busy}, 32'd3);
        check("s5_busy_after", {31'd0, busy}, 32'd0);
        cycle();
        check("s5_drop_once", drop_cnt, 1);
        check("s5_obs_idle", {31'd0, o_busy}, 32'd0);

        // Reset mid-packet, then arbitrate from requester 0.
        do_reset();
        for (int k = 0; k < 5; k++) load(2, 8'(8'hE0 + k), k == 4);
        en = 4'b1111;
        set_inputs();
        run_until_writes("s6_first2", 2, 10);
        reset = 1'b0;
        #1;
        check("s6_async_outputs", {18'd0, busy, wr_uart, drop, ack, w_data}, 32'd0);
        check("s6_async_owner", {29'd0, owner}, 32'd0);
        repeat (3) cycle();
        check("s6_no_write_in_reset", wr_owner.size(), 2);
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        load(0, 8'h77, 1'b1);
        load(3, 8'h99, 1'b1);
        set_inputs();
        reset = 1'b1;
        run_until_writes("s6_after", 3, 10);
        check("s6_owner0", wr_owner[2], 0);
        check("s6_byte", wr_byte[2], 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
